// File: rtl/udma_jtag_host_pkg.sv
// Shared types and constants for the uDMA JTAG FIFO host-side DR-scan initiator.
package udma_jtag_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_UPDATE  = 2'd3
    } jtag_state_e;

    // Position of the valid flag inside a scan frame; data sits above it.
    localparam int unsigned FLAG_BIT = 0;

    function automatic int unsigned frame_w(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/udma_jtag_host_tckgen.sv
// TCK generator: divides clk_i down to TCK and flags the clk_i cycle of each TCK edge.
module udma_jtag_host_tckgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic idle_i,
    output logic tck_o,
    output logic tck_rise_c_o,
    output logic tck_fall_c_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tck_q, tck_d;
    logic             run_c, wrap_c;

    // Disabling only stops TCK once the FSM is idle and TCK is already low.
    always_comb begin
        run_c  = en_i | ~idle_i | tck_q;
        wrap_c = run_c && (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = div_q;
        tck_d  = tck_q;
        if (run_c) begin
            div_d = wrap_c ? '0 : div_q + DIV_W'(1);
        end
        if (wrap_c) begin
            tck_d = ~tck_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o        = tck_q;
    assign tck_rise_c_o = wrap_c & ~tck_q;
    assign tck_fall_c_o = wrap_c &  tck_q;

endmodule

// File: rtl/udma_jtag_fifo_host.sv
// JTAG DR-scan initiator: exchanges one flagged word per scan with a uDMA JTAG FIFO target.
module udma_jtag_fifo_host
    import udma_jtag_host_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_poll_en_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  jtag_tck_o,
    output logic                  jtag_tdi_o,
    input  logic                  jtag_tdo_i,
    output logic                  jtag_trstn_o,
    output logic                  jtag_capture_dr_o,
    output logic                  jtag_shift_dr_o,
    output logic                  jtag_update_dr_o,
    output logic                  jtag_pause_dr_o
);

    localparam int unsigned FRAME_W = frame_w(DATA_WIDTH);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    jtag_state_e               state_q, state_d;
    logic [FRAME_W-1:0]        shift_q, shift_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      tdi_q, tdi_d;
    logic                      cap_q, cap_d;
    logic                      sdr_q, sdr_d;
    logic                      upd_q, upd_d;
    logic                      busy_q, busy_d;
    logic                      trstn_q;
    logic [DATA_WIDTH-1:0]     rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      tx_ready_c;
    logic                      rise_c, fall_c;

    udma_jtag_host_tckgen #(
        .CLK_DIV (CLK_DIV)
    ) u_tckgen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (cfg_en_i),
        .idle_i       (state_q == ST_IDLE),
        .tck_o        (jtag_tck_o),
        .tck_rise_c_o (rise_c),
        .tck_fall_c_o (fall_c)
    );

    // Scan FSM: strobes and TDI move on TCK fall, TDO is captured on TCK rise.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tdi_d      = tdi_q;
        cap_d      = cap_q;
        sdr_d      = sdr_q;
        upd_d      = upd_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_ready_c = 1'b0;

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_c && cfg_en_i && !rx_valid_q && (tx_valid_i || cfg_poll_en_i)) begin
                    if (tx_valid_i) begin
                        shift_d    = {tx_data_i, 1'b1};
                        tx_ready_c = 1'b1;
                    end else begin
                        shift_d = '0;
                    end
                    cap_d   = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (fall_c) begin
                    cap_d   = 1'b0;
                    sdr_d   = 1'b1;
                    tdi_d   = shift_q[FLAG_BIT];
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_c) begin
                    shift_d = {jtag_tdo_i, shift_q[FRAME_W-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (fall_c) begin
                    if (cnt_q == CNT_W'(FRAME_W)) begin
                        sdr_d   = 1'b0;
                        upd_d   = 1'b1;
                        tdi_d   = 1'b0;
                        state_d = ST_UPDATE;
                    end else begin
                        tdi_d = shift_q[FLAG_BIT];
                    end
                end
            end
            ST_UPDATE: begin
                if (fall_c) begin
                    upd_d   = 1'b0;
                    state_d = ST_IDLE;
                    // Flag-0 frames carry no payload and are dropped.
                    if (shift_q[FLAG_BIT]) begin
                        rx_data_d  = shift_q[FRAME_W-1:1];
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tdi_q      <= 1'b0;
            cap_q      <= 1'b0;
            sdr_q      <= 1'b0;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            trstn_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tdi_q      <= tdi_d;
            cap_q      <= cap_d;
            sdr_q      <= sdr_d;
            upd_q      <= upd_d;
            busy_q     <= busy_d;
            trstn_q    <= 1'b1;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready_o        = tx_ready_c;
    assign rx_data_o         = rx_data_q;
    assign rx_valid_o        = rx_valid_q;
    assign busy_o            = busy_q;
    assign jtag_tdi_o        = tdi_q;
    assign jtag_trstn_o      = trstn_q;
    assign jtag_capture_dr_o = cap_q;
    assign jtag_shift_dr_o   = sdr_q;
    assign jtag_update_dr_o  = upd_q;
    assign jtag_pause_dr_o   = 1'b0;

endmodule
